// File: rtl/score_bcd_seg7.sv
// score_bcd_seg7: converts a binary score to BCD one bit per clock with shift-add-3.
// It then registers the active-low seven-segment patterns for each digit.
// Ports: clk, rst (async, active-low), start, value[WIDTH] -> busy, done,
//        overflow, bcd[4*DIGITS] (digit 0 = ones), seg[7*DIGITS] (bit0=a..bit6=g).
// Option: define LEADING_ZERO_BLANK_EN to blank digits above the most
//         significant nonzero digit (digit 0 is never blanked).
module score_bcd_seg7 #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // Reset shows a zero score, laid out as the display would show it.
    function automatic logic [SW-1:0] seg_reset();
        logic [SW-1:0] s;
        s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            s[7*i +: 7] = SEG_ZERO;
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0) s[7*i +: 7] = SEG_BLANK;
`endif
        end
        return s;
    endfunction

    localparam logic [SW-1:0] SEG_RST = seg_reset();

    state_t          state;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]   acc;
    logic [BW-1:0]   adj;
    logic [CW-1:0]   cnt;
    logic            sticky;
    logic [SW-1:0]   seg_next;

    // Per-digit add-3 correction ahead of the shift.
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        logic [3:0] d;
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        seg_next = '0;
        d = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = acc[4*i +: 4];
            if (sticky) seg_next[7*i +: 7] = SEG_DASH;
            else        seg_next[7*i +: 7] = enc(d);
`ifdef LEADING_ZERO_BLANK_EN
            // Still scanning zeros from the top: blank, except the ones digit.
            if (!sticky && lead && i > 0 && d == 4'd0)
                seg_next[7*i +: 7] = SEG_BLANK;
            if (d != 4'd0) lead = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            sreg     <= '0;
            acc      <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
            seg      <= SEG_RST;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        sreg   <= value;
                        acc    <= '0;
                        sticky <= 1'b0;
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // The bit leaving the accumulator top is a lost power of ten.
                    if (adj[BW-1]) sticky <= 1'b1;
                    {acc, sreg} <= {adj, sreg} << 1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_DONE;
                end
                S_DONE: begin
                    bcd      <= acc;
                    seg      <= seg_next;
                    overflow <= sticky;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_seg7.sv
// Self-checking bench for score_bcd_seg7 (3-digit and 2-digit instances, WIDTH=7).
// Honours LEADING_ZERO_BLANK_EN in its expectations.
module tb_score_bcd_seg7;

    localparam int W = 7;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam logic [6:0] LZ = BLANK ? 7'h7F : 7'h40;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] value = '0;

    logic         busy, done, ovf;
    logic [11:0]  bcd;
    logic [20:0]  seg;
    logic         busy2, done2, ovf2;
    logic [7:0]   bcd2;
    logic [13:0]  seg2;

    int total = 0;
    int bad   = 0;

    logic [6:0] enc_t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        int          v;
        logic [11:0] b;
        logic [20:0] s;
    } vec_t;

    vec_t tbl [7];

    score_bcd_seg7 #(.WIDTH(W), .DIGITS(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy), .done(done), .overflow(ovf), .bcd(bcd), .seg(seg)
    );

    score_bcd_seg7 #(.WIDTH(W), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy2), .done(done2), .overflow(ovf2), .bcd(bcd2), .seg(seg2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] m_bcd(input int v, input int d);
        logic [31:0] res = '0;
        int r = v % pow10(d);
        for (int i = 0; i < d; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    function automatic logic [31:0] m_ovf(input int v, input int d);
        return (v > pow10(d) - 1) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] m_seg(input int v, input int d);
        logic [31:0] res = '0;
        bit ov = (v > pow10(d) - 1);
        int r = v % pow10(d);
        for (int i = 0; i < d; i++) begin
            if (ov)
                res[7*i +: 7] = 7'h3F;
            else if (BLANK && i > 0 && r < pow10(i))
                res[7*i +: 7] = 7'h7F;
            else
                res[7*i +: 7] = enc_t[(r / pow10(i)) % 10];
        end
        return res;
    endfunction

    task automatic check_all(input int v);
        chk("bcd3", bcd,  m_bcd(v, 3));
        chk("seg3", seg,  m_seg(v, 3));
        chk("ovf3", ovf,  m_ovf(v, 3));
        chk("bcd2", bcd2, m_bcd(v, 2));
        chk("seg2", seg2, m_seg(v, 2));
        chk("ovf2", ovf2, m_ovf(v, 2));
    endtask

    task automatic check_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf",  ovf,  0);
        chk("rst_bcd",  bcd,  0);
        chk("rst_seg",  seg,  m_seg(0, 3));
        chk("rst_seg2", seg2, m_seg(0, 2));
        chk("rst_busy2", busy2, 0);
    endtask

    task automatic issue(input int v);
        start = 1'b1;
        value = W'(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_done", done, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        int bz = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!done && !busy) bz++;
        end
        chk("latency", n, 8);
        chk("busy_hold", bz, 0);
        chk("done_busy", busy, 0);
        chk("done_sync", done2, done);
    endtask

    initial begin
        tbl[0] = '{127, 12'h127, {7'h79, 7'h24, 7'h78}};
        tbl[1] = '{0,   12'h000, {LZ, LZ, 7'h40}};
        tbl[2] = '{5,   12'h005, {LZ, LZ, 7'h12}};
        tbl[3] = '{12,  12'h012, {LZ, 7'h79, 7'h24}};
        tbl[4] = '{88,  12'h088, {LZ, 7'h00, 7'h00}};
        tbl[5] = '{64,  12'h064, {LZ, 7'h02, 7'h19}};
        tbl[6] = '{100, 12'h100, {7'h79, 7'h40, 7'h40}};

        repeat (2) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            issue(tbl[i].v);
            wait_done();
            chk($sformatf("tbl_bcd[%0d]", i), bcd, tbl[i].b);
            chk($sformatf("tbl_seg[%0d]", i), seg, tbl[i].s);
            chk($sformatf("tbl_ovf[%0d]", i), ovf, 0);
        end

        // Overflow on the two-digit display, then recovery.
        @(negedge clk);
        issue(100);
        wait_done();
        chk("ovf2_set", ovf2, 1);
        chk("ovf2_seg", seg2, {7'h3F, 7'h3F});
        chk("ovf2_bcd", bcd2, 8'h00);
        @(negedge clk);
        issue(99);
        wait_done();
        chk("ovf2_clr", ovf2, 0);
        chk("ovf2_seg99", seg2, {7'h10, 7'h10});
        chk("ovf2_bcd99", bcd2, 8'h99);

        // start/value during a conversion must be ignored.
        begin
            int nd = 0;
            int first = -1;
            int bb = 0;
            @(negedge clk);
            issue(12);
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk);
                #1;
                if (done) begin
                    nd++;
                    if (first < 0) first = c;
                end
                if (busy !== (c < 8)) bb++;
                if (c == 2) begin
                    start = 1'b1;
                    value = W'(45);
                end
                if (c == 5) start = 1'b0;
            end
            chk("ign_ndone", nd, 1);
            chk("ign_first", first, 8);
            chk("ign_busy", bb, 0);
            chk("ign_bcd", bcd, 12'h012);
            chk("ign_seg", seg, m_seg(12, 3));
        end

        // Back-to-back: start during the done cycle.
        @(negedge clk);
        issue(127);
        wait_done();
        check_all(127);
        issue(88);
        wait_done();
        check_all(88);

        // Asynchronous reset mid-conversion.
        @(negedge clk);
        issue(99);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(64);
        wait_done();
        check_all(64);
        chk("post_rst_bcd", bcd, 12'h064);

        // Random values; value is scrambled mid-conversion.
        for (int k = 0; k < 30; k++) begin
            int v;
            v = int'($urandom_range(0, 127));
            @(negedge clk);
            issue(v);
            value = W'($urandom);
            wait_done();
            check_all(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
